// File: rtl/mealy_5bit_pkg.sv
// Shared definitions for the serial 0-0-1-1-0 Mealy detector.
// States are named by the longest pattern prefix matched so far.
package mealy_5bit_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // no prefix
    S1 = 3'd1,  // "0"
    S2 = 3'd2,  // "00"
    S3 = 3'd3,  // "001"
    S4 = 3'd4   // "0011"
  } state_t;

  // MSB is the first bit received on the serial line.
  localparam logic [4:0] PATTERN     = 5'b00110;
  localparam int         PATTERN_LEN = 5;

endpackage

// File: rtl/mealy_5bit_detector.sv
// Serial Mealy detector for 0-0-1-1-0 with overlap; op is combinational (zero latency).
// No backpressure: one bit is consumed on every rising clk edge.
module mealy_5bit_detector
  import mealy_5bit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ip,
  output logic op
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S0;
    op         = 1'b0;
    case (state)
      S0: next_state = ip ? S0 : S1;
      S1: next_state = ip ? S0 : S2;
      S2: next_state = ip ? S3 : S2;
      S3: next_state = ip ? S4 : S1;
      S4: begin
        // The completing 0 also seeds the next overlapping match.
        next_state = ip ? S0 : S1;
        op         = ~ip & ~rst;
      end
      default: begin
        next_state = S0;
        op         = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mealy_5bit_detector.sv
// Directed-vector bench for mealy_5bit_detector with a queue-based scoreboard.
// Stimulus pushes hand-computed expected op values; a monitor pops and compares each cycle.
module tb_mealy_5bit_detector;

  logic clk;
  logic rst;
  logic ip;
  logic op;

  typedef struct {
    string name;
    int    idx;
    logic  exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  mealy_5bit_detector dut (
    .clk(clk),
    .rst(rst),
    .ip (ip),
    .op (op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: op is combinational, so sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (op !== e.exp) begin
          n_err++;
          $display("FAIL %s bit %0d: op=%b expected %b", e.name, e.idx, op, e.exp);
        end
      end
    end
  end

  task automatic apply(input string name, input int idx, input logic r, input logic b,
                       input logic e);
    exp_t item;
    @(posedge clk);
    #1;
    rst = r;
    ip  = b;
    item.name = name;
    item.idx  = idx;
    item.exp  = e;
    exp_q.push_back(item);
  endtask

  // bits/exp are listed first-bit-first in the low n bits (bit n-1 applied first).
  task automatic run_seq(input string name, input int n, input logic [31:0] bits,
                         input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--)
      apply(name, n - i, 1'b0, bits[i], exp[i]);
  endtask

  task automatic do_reset(input string name, input int cycles);
    for (int i = 0; i < cycles; i++)
      apply(name, i + 1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    ip    = 1'b0;

    do_reset("reset", 2);
    run_seq("basic", 6, 32'b001100, 32'b000010);

    do_reset("rst_a", 1);
    run_seq("overlap", 9, 32'b001100110, 32'b000010001);

    do_reset("rst_b", 1);
    run_seq("near_000110", 6, 32'b000110, 32'b000001);

    do_reset("rst_c", 1);
    run_seq("near_00100110", 8, 32'b00100110, 32'b00000001);

    do_reset("rst_d", 1);
    run_seq("near_001110", 6, 32'b001110, 32'b000000);

    // Reset arrives in S4 with ip=0: reset must suppress the detect.
    do_reset("rst_e", 1);
    run_seq("mid_pre", 4, 32'b0011, 32'b0000);
    apply("mid_rst", 1, 1'b1, 1'b0, 1'b0);
    run_seq("mid_post", 1, 32'b0, 32'b0);
    run_seq("mid_redetect", 5, 32'b00110, 32'b00001);

    do_reset("rst_f", 1);
    run_seq("idle_ones", 16, 32'h0000_ffff, 32'h0);
    run_seq("idle_zeros", 16, 32'h0, 32'h0);
    run_seq("idle_tail", 3, 32'b110, 32'b001);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
